// File: rtl/regfile_sb.sv
// Multi-read-port register file with a write-pending scoreboard for decode/writeback.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wen,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]           rbusy,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  output logic                       issue_ready,
  input  logic                       flush,
  output logic [ADDR_WIDTH:0]        pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [CW-1:0]         cnt;
  logic                  wr_ok;
  logic                  issue_acc;
  logic                  cnt_inc;
  logic                  cnt_dec;

  // A same-cycle writeback to issue_rd frees it, so only a true WAW stalls.
  assign wr_ok       = wen && !is_zero(waddr);
  assign issue_ready = !flush && (is_zero(issue_rd) || !busy[issue_rd] ||
                                  (wen && (waddr == issue_rd)));
  assign issue_acc   = issue_valid && issue_ready && !is_zero(issue_rd);

  // Counter deltas mirror the busy update; issue beats writeback on the same index.
  assign cnt_inc = issue_acc && !busy[issue_rd];
  assign cnt_dec = wr_ok && busy[waddr] && !(issue_acc && (issue_rd == waddr));

  always_comb begin
    busy_next = busy;
    if (wr_ok)     busy_next[waddr]    = 1'b0;
    if (issue_acc) busy_next[issue_rd] = 1'b1;
    if (flush)     busy_next           = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      busy <= busy_next;
      if (flush) cnt <= '0;
      else       cnt <= cnt + CW'(cnt_inc) - CW'(cnt_dec);
      if (wr_ok) rf[waddr] <= wdata;
    end
  end

  assign pending_cnt = cnt;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = rf[ra];
      rb = busy[ra];
`ifdef RF_BYPASS_EN
      if (wr_ok && (waddr == ra)) begin
        rd = wdata;
        rb = 1'b0;
      end
`endif
      if (is_zero(ra)) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[i] = rb;
  end

  a_cnt_popcount: assert property (@(posedge clk) disable iff (!rst_n)
                                   cnt == CW'($countones(busy)));

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb (default parameters).
// Expected values are queued when stimulus is applied and popped at each check.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic              clk;
  logic              rst_n;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_ready;
  logic              flush;
  logic [AW:0]       pending_cnt;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic iv, input logic [AW-1:0] ird, input logic fl);
    wen         = w;
    waddr       = wa;
    wdata       = wd;
    issue_valid = iv;
    issue_rd    = ird;
    flush       = fl;
  endtask

  task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic pushExp(input string tag, input logic [63:0] e);
    exp_t t;
    t.tag = tag;
    t.exp = e;
    sbq.push_back(t);
  endtask

  task automatic checkOutput(input logic [63:0] obs);
    exp_t t;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("[TB] FAIL sb_empty got=%h", obs);
    end else begin
      t = sbq.pop_front();
      assert (obs === t.exp) else begin
        bad++;
        $error("[TB] FAIL %s got=%h exp=%h", t.tag, obs, t.exp);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd3, 5'd7);
    #12;
    rst_n = 1'b1;
    #1;

    // reset state
    pushExp("rst_rd3", 64'h0);
    pushExp("rst_rd7", 64'h0);
    pushExp("rst_rbusy", 64'h0);
    pushExp("rst_pend", 64'h0);
    pushExp("rst_ready", 64'h1);
    checkOutput(64'(rdata[31:0]));
    checkOutput(64'(rdata[63:32]));
    checkOutput(64'(rbusy));
    checkOutput(64'(pending_cnt));
    checkOutput(64'(issue_ready));

    // issue x5, reissue stalls, writeback frees it
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd5, 1'b0);
    pushExp("iss5_ready", 64'h1);
    checkOutput(64'(issue_ready));
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd5, 1'b0);
    setRead(5'd5, 5'd0);
    #1;
    pushExp("x5_busy", 64'h1);
    pushExp("x5_pend", 64'h1);
    pushExp("reiss5_ready", 64'h0);
    checkOutput(64'(rbusy[0]));
    checkOutput(64'(pending_cnt));
    checkOutput(64'(issue_ready));
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    pushExp("wb5_data", 64'hDEADBEEF);
    pushExp("wb5_busy", 64'h0);
    pushExp("wb5_pend", 64'h0);
    checkOutput(64'(rdata[31:0]));
    checkOutput(64'(rbusy[0]));
    checkOutput(64'(pending_cnt));

    // hardwired zero register
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0);
    setRead(5'd0, 5'd0);
    #1;
    pushExp("x0_ready", 64'h1);
    checkOutput(64'(issue_ready));
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    pushExp("x0_data", 64'h0);
    pushExp("x0_rbusy", 64'h0);
    pushExp("x0_pend", 64'h0);
    checkOutput(64'(rdata[31:0]));
    checkOutput(64'(rbusy));
    checkOutput(64'(pending_cnt));

    // same-cycle writeback and reissue of x9
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'hA5, 1'b1, 5'd9, 1'b0);
    setRead(5'd9, 5'd0);
    #1;
    pushExp("x9_ready", 64'h1);
    pushExp("x9_pend_pre", 64'h1);
    checkOutput(64'(issue_ready));
    checkOutput(64'(pending_cnt));
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    pushExp("x9_data", 64'hA5);
    pushExp("x9_busy", 64'h1);
    pushExp("x9_pend", 64'h1);
    checkOutput(64'(rdata[31:0]));
    checkOutput(64'(rbusy[0]));
    checkOutput(64'(pending_cnt));

    // flush with competing issue and writeback
    applyStimulus(1'b1, 5'd9, 32'hA5, 1'b0, '0, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(k), 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    pushExp("pre_flush_pend", 64'h3);
    checkOutput(64'(pending_cnt));
    applyStimulus(1'b1, 5'd2, 32'h77, 1'b1, 5'd4, 1'b1);
    #1;
    pushExp("flush_ready", 64'h0);
    checkOutput(64'(issue_ready));
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(5'd1, 5'd3);
    #1;
    pushExp("flush_rbusy13", 64'h0);
    pushExp("flush_pend", 64'h0);
    checkOutput(64'(rbusy));
    checkOutput(64'(pending_cnt));
    setRead(5'd2, 5'd4);
    #1;
    pushExp("flush_x2", 64'h77);
    pushExp("flush_x4_busy", 64'h0);
    checkOutput(64'(rdata[31:0]));
    checkOutput(64'(rbusy[1]));

    // same-cycle read of a register being written
    applyStimulus(1'b1, 5'd6, 32'h55, 1'b0, '0, 1'b0);
    setRead(5'd6, 5'd0);
    #1;
`ifdef RF_BYPASS_EN
    pushExp("byp_x6", 64'h55);
`else
    pushExp("byp_x6", 64'h0);
`endif
    pushExp("byp_x6_busy", 64'h0);
    checkOutput(64'(rdata[31:0]));
    checkOutput(64'(rbusy[0]));
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    pushExp("post_x6", 64'h55);
    checkOutput(64'(rdata[31:0]));

    // async reset with four registers pending
    for (int k = 10; k <= 13; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(k), 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd10, 1'b0);
    setRead(5'd10, 5'd6);
    #1;
    pushExp("four_pend", 64'h4);
    pushExp("four_rbusy", 64'h1);
    pushExp("four_ready", 64'h0);
    checkOutput(64'(pending_cnt));
    checkOutput(64'(rbusy));
    checkOutput(64'(issue_ready));
    rst_n = 1'b0;
    #1;
    pushExp("arst_pend", 64'h0);
    pushExp("arst_rbusy", 64'h0);
    pushExp("arst_x6", 64'h0);
    pushExp("arst_ready", 64'h1);
    checkOutput(64'(pending_cnt));
    checkOutput(64'(rbusy));
    checkOutput(64'(rdata[63:32]));
    checkOutput(64'(issue_ready));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Multi-read-port, single-write-port integer register file with an integrated write-pending scoreboard, for the NPC pipeline decode/writeback stages.
- Parametrised in width, depth and read-port count. Optional hardwired-zero register.
- Busy bits track registers that have an in-flight writer, so decode can stall on RAW/WAW hazards without a separate scoreboard block.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- NREAD, 2, number of read ports (>=1)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never becomes busy

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- wen  in  1  writeback enable
- waddr  in  ADDR_WIDTH  writeback index
- wdata  in  DATA_WIDTH  writeback data
- raddr  in  NREAD*ADDR_WIDTH  read indices; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NREAD*DATA_WIDTH  read data, same packing, combinational
- rbusy  out  NREAD  1 = the register at raddr[i] has a pending writer
- issue_valid  in  1  decode requests to mark issue_rd pending
- issue_rd  in  ADDR_WIDTH  destination register of the issuing instruction
- issue_ready  out  1  issue accepted this cycle when issue_valid && issue_ready
- flush  in  1  synchronous clear of all busy bits (pipeline squash)
- pending_cnt  out  ADDR_WIDTH+1  number of busy registers

Behaviour:
- Reset (rst_n low, async): all registers = 0; all busy bits = 0; pending_cnt = 0. Hence rdata = 0, rbusy = 0 and issue_ready = 1 immediately after reset. Reset mid-operation discards all pending state.
- Write: on posedge with wen, rf[waddr] <= wdata and busy[waddr] <= 0. When ZERO_REG=1 and waddr==0, the write is dropped.
- Writes to a non-busy register are legal: data is written and busy stays 0.
- Read: rdata[i] = rf[raddr[i]] and rbusy[i] = busy[raddr[i]], both combinational. Zero latency.
- When ZERO_REG=1: index 0 reads 0 and rbusy reads 0.
- issue_ready = !flush && (!busy[issue_rd] || (wen && waddr==issue_rd)). This stalls WAW only; a writeback to the same register in the same cycle frees it.
- issue_ready = 1 always for issue_rd==0 when ZERO_REG=1.
- Accepted issue: busy[issue_rd] <= 1 on posedge. If wen && waddr==issue_rd in the same cycle, the data is written and the busy bit ends at 1, because the new writer wins.
- Issue to register 0 with ZERO_REG=1 is accepted with no state change.
- flush: on posedge all busy bits <= 0. A same-cycle wen still writes data. Any same-cycle issue is not accepted, since issue_ready=0 while flush is high.
- pending_cnt: registered popcount of busy. It updates on the same edge as busy:
  - +1 for an accepted issue to a non-busy register
  - -1 for a wen clearing a busy register
  - net 0 when both happen to different registers, or when issue and wen hit the same register
  - 0 on flush
  - never exceeds 2**ADDR_WIDTH - ZERO_REG
- Assertion: pending_cnt always equals popcount(busy).

Optional Feature:
- RF_BYPASS_EN defined: write-through forwarding. For each port, if wen && waddr==raddr[i] (and not hardwired zero), rdata[i] = wdata and rbusy[i] = 0 in the same cycle.
- RF_BYPASS_EN undefined: rdata[i] and rbusy[i] reflect only stored state; the written value is visible on the cycle after the write edge.

Test Plan:
- Reset then read: release rst_n; raddr = {3,7} -> rdata = {0,0}, rbusy = 00, pending_cnt = 0, issue_ready = 1.
- Issue/writeback: issue rd=5 -> next cycle rbusy for x5 = 1, pending_cnt = 1. Reissue rd=5 -> issue_ready = 0. wen x5 = 0xDEADBEEF -> next cycle rdata = 0xDEADBEEF, rbusy = 0, pending_cnt = 0.
- Zero register (ZERO_REG=1): wen x0 = 0x1234 and issue rd=0 -> x0 reads 0, rbusy = 0, pending_cnt = 0, issue_ready = 1.
- Simultaneous events: x9 busy; same cycle wen x9 = 0xA5 and issue rd=9 -> issue_ready = 1; next cycle rdata = 0xA5, rbusy = 1, pending_cnt unchanged at 1.
- Flush: issue rd = 1, 2, 3 (pending_cnt = 3); flush with issue_valid rd=4 and wen x2 = 0x77 -> issue_ready = 0; next cycle all rbusy = 0, pending_cnt = 0, x2 reads 0x77, x4 not busy.
- Bypass and async reset: with RF_BYPASS_EN, wen x6 = 0x55 and raddr x6 -> same-cycle rdata = 0x55, rbusy = 0; without it, the old value appears that cycle. Then assert rst_n low mid-cycle with 4 regs busy -> outputs zero immediately, without waiting for a clock edge.
